// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths used by fetch, the instruction
// register and the decoder, plus the fetch unit's state encoding.
package cpu_pkg;

    localparam int INST_W = 18;
    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch unit: wrap-around increment, direct load,
// and a one-entry latch that parks a redirect target while a memory request
// is in flight (the request address must not move until it is acknowledged).
module fetch_pc
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              capture_redirect,
    input  logic              apply_redirect,
    output logic [ADDR_W-1:0] pc,
    output logic              redir_pend
);

    logic [ADDR_W-1:0] redir_pc;

    // PC update (load beats a parked redirect beats increment) and redirect latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of its neighbours, independent of statement order.
            if (load) begin
                pc <= load_addr;
            end else if (apply_redirect) begin
                pc <= redir_pc;
            end else if (inc) begin
                pc <= pc + 1'b1;  // wraps naturally at 2^ADDR_W
            end

            if (apply_redirect) begin
                redir_pend <= 1'b0;
            end else if (capture_redirect) begin
                redir_pend <= 1'b1;
                redir_pc   <= load_addr;  // a later jump simply overwrites
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests words from instruction memory at the
// current PC, buffers each returned word for the instruction register and
// handles jump redirects, discarding any fetch made stale by a jump.
// All outputs come straight from registers.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_data_i,
    output logic              ack_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              ready_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              redir_pend;
    logic              pc_inc;
    logic              pc_load;
    logic              pc_capture;
    logic              pc_apply;

    fetch_pc #(
        .RESET_PC(RESET_PC)
    ) u_fetch_pc (
        .clk              (clk),
        .rst              (rst),
        .inc              (pc_inc),
        .load             (pc_load),
        .load_addr        (jump_addr_i),
        .capture_redirect (pc_capture),
        .apply_redirect   (pc_apply),
        .pc               (pc),
        .redir_pend       (redir_pend)
    );

    // The PC register is the request address, so it is stable while waiting.
    assign mem_addr_o = pc;

    // PC control: jumps land directly except mid-request, where they are parked.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_capture = 1'b0;
        pc_apply   = 1'b0;
        case (state)
            S_IDLE:  pc_load = jump_i;
            S_FETCH: begin
                if (mem_ack_i) begin
                    if (redir_pend) begin
                        pc_apply = 1'b1;
                        pc_load  = jump_i;  // a fresh jump beats the parked one
                    end else if (jump_i) begin
                        pc_load = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end else begin
                    pc_capture = jump_i;
                end
            end
            S_VALID: pc_load = jump_i;
            default: ;
        endcase
    end

    // Fetch FSM with registered request, ack and instruction buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mem_req_o <= 1'b0;
            ack_o     <= 1'b0;
            inst_o    <= '0;
            pc_o      <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_FETCH;
                    mem_req_o <= 1'b1;
                end
                S_FETCH: begin
                    // Data is kept only when no redirect made this fetch stale.
                    if (mem_ack_i && !redir_pend && !jump_i) begin
                        inst_o    <= mem_data_i;
                        pc_o      <= pc;
                        state     <= S_VALID;
                        mem_req_o <= 1'b0;
                        ack_o     <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (jump_i || ready_i) begin
                        state     <= S_FETCH;
                        mem_req_o <= 1'b1;
                        ack_o     <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    mem_req_o <= 1'b0;
                    ack_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural instruction memory and a
// scoreboard of the words expected on the instruction-register interface.
module tb_inst_fetch;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [INST_W-1:0] mem_data_i;
    logic              ack_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_o;
    logic              ready_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_addr_i;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   mem_lat = 1;

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i),
        .ack_o       (ack_o),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .ready_i     (ready_i),
        .jump_i      (jump_i),
        .jump_addr_i (jump_addr_i)
    );

    always #5 clk = ~clk;

    // Memory contents: two fixed words, everything else derived from the address.
    function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 12'h000) return 18'h12345;
        if (a == 12'h001) return 18'h00ABC;
        return {~a[5:0], a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = mem_word(a);
        sb.push_back(e);
    endtask

    // Wait (bounded) for ack_o, then compare against the oldest expectation.
    task automatic wait_ack(input string tag, input int budget);
        int   n = 0;
        exp_t e;
        do begin
            @(negedge clk);
            n++;
        end while (ack_o !== 1'b1 && n < budget);
        chk({tag, "_ack"}, 32'(ack_o), 32'd1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_inst"}, 32'(inst_o), 32'(e.inst));
            chk({tag, "_pc"}, 32'(pc_o), 32'(e.pc));
        end
    endtask

    // Memory responder: acks mem_lat cycles into a request, one-cycle ack pulse.
    initial begin
        int cnt = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end else if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end else if (mem_req_o) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_word(mem_addr_o);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        rst         = 1'b1;
        ready_i     = 1'b1;
        jump_i      = 1'b0;
        jump_addr_i = '0;
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_inst", 32'(inst_o), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);

        // Sequential fetch, one transfer every two cycles
        @(negedge clk);
        chk("idle_req", 32'(mem_req_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("seq0_req", 32'(mem_req_o), 32'd1);
        chk("seq0_addr", 32'(mem_addr_o), 32'h000);
        push_exp(12'h000);
        wait_ack("seq0", 4);
        push_exp(12'h001);
        @(negedge clk);
        chk("seq1_gap_ack", 32'(ack_o), 32'd0);
        chk("seq1_req", 32'(mem_req_o), 32'd1);
        chk("seq1_addr", 32'(mem_addr_o), 32'h001);
        wait_ack("seq1", 1);
        @(negedge clk);
        chk("seq2_req", 32'(mem_req_o), 32'd1);
        chk("seq2_addr", 32'(mem_addr_o), 32'h002);
        ready_i = 1'b0;
        push_exp(12'h002);
        wait_ack("seq2", 4);

        // Jump back to 0 from S_VALID while stalled, then stall on 0x12345
        jump_i      = 1'b1;
        jump_addr_i = 12'h000;
        @(negedge clk);
        jump_i = 1'b0;
        chk("j0_ack", 32'(ack_o), 32'd0);
        chk("j0_req", 32'(mem_req_o), 32'd1);
        chk("j0_addr", 32'(mem_addr_o), 32'h000);
        push_exp(12'h000);
        wait_ack("j0", 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ack", 32'(ack_o), 32'd1);
            chk("stall_inst", 32'(inst_o), 32'h12345);
            chk("stall_pc", 32'(pc_o), 32'h000);
            chk("stall_req", 32'(mem_req_o), 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk("post_stall_req", 32'(mem_req_o), 32'd1);
        chk("post_stall_addr", 32'(mem_addr_o), 32'h001);
        ready_i = 1'b0;
        push_exp(12'h001);
        wait_ack("post_stall", 4);

        // Jump while S_VALID with ready_i=0
        jump_i      = 1'b1;
        jump_addr_i = 12'h200;
        @(negedge clk);
        jump_i = 1'b0;
        chk("j200_ack", 32'(ack_o), 32'd0);
        chk("j200_addr", 32'(mem_addr_o), 32'h200);
        chk("j200_req", 32'(mem_req_o), 32'd1);
        ready_i = 1'b1;
        push_exp(12'h200);
        wait_ack("j200", 4);

        // Two jumps during an outstanding 3-cycle request
        mem_lat = 3;
        @(negedge clk);
        chk("out_req", 32'(mem_req_o), 32'd1);
        chk("out_addr0", 32'(mem_addr_o), 32'h201);
        jump_i      = 1'b1;
        jump_addr_i = 12'h040;
        @(negedge clk);
        chk("out_addr1", 32'(mem_addr_o), 32'h201);
        jump_addr_i = 12'h080;
        @(negedge clk);
        jump_i = 1'b0;
        chk("out_addr2", 32'(mem_addr_o), 32'h201);
        chk("out_ack2", 32'(ack_o), 32'd0);
        @(negedge clk);
        chk("redir_ack", 32'(ack_o), 32'd0);
        chk("redir_req", 32'(mem_req_o), 32'd1);
        chk("redir_addr", 32'(mem_addr_o), 32'h080);
        mem_lat = 1;
        push_exp(12'h080);
        wait_ack("redir", 4);

        // Wrap-around from 0xFFF (jump with ready_i=1 in S_VALID)
        jump_i      = 1'b1;
        jump_addr_i = 12'hFFF;
        @(negedge clk);
        jump_i = 1'b0;
        chk("wrap_addr0", 32'(mem_addr_o), 32'hFFF);
        push_exp(12'hFFF);
        push_exp(12'h000);
        wait_ack("wrap0", 4);
        @(negedge clk);
        chk("wrap_addr1", 32'(mem_addr_o), 32'h000);
        chk("wrap_req1", 32'(mem_req_o), 32'd1);
        wait_ack("wrap1", 4);

        // Asynchronous reset between clock edges with a request in flight
        mem_lat = 3;
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req_o), 32'd1);
        chk("pre_rst_addr", 32'(mem_addr_o), 32'h001);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req_o), 32'd0);
        chk("arst_ack", 32'(ack_o), 32'd0);
        chk("arst_inst", 32'(inst_o), 32'd0);
        chk("arst_pc", 32'(pc_o), 32'd0);
        chk("arst_addr", 32'(mem_addr_o), 32'd0);
        @(negedge clk);
        chk("arst_hold_req", 32'(mem_req_o), 32'd0);
        mem_lat = 1;
        rst = 1'b1;
        #2;
        chk("arst_idle_req", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        chk("arst_fetch_req", 32'(mem_req_o), 32'd1);
        chk("arst_fetch_addr", 32'(mem_addr_o), 32'h000);
        push_exp(12'h000);
        wait_ack("post_rst", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
